// File: rtl/control_plane_pkg.sv
// control_plane_pkg: shared types, constants and packet helpers for the control plane
package control_plane_pkg;
  localparam logic [31:0] CP_IDLE_PKT = 32'hFFFF_FFFF;
  typedef enum logic [1:0] {TX_IDLE, TX_ANNOUNCE, TX_LAUNCH} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_BUSY, RX_DONE} rx_state_t;
  function automatic logic [15:0] pkt_src(input logic [31:0] p);
    return p[31:16];
  endfunction
  function automatic logic [15:0] pkt_dst(input logic [31:0] p);
    return p[15:0];
  endfunction
  function automatic logic [15:0] eff_nodes(input logic signed [15:0] m);
    return m <= 16'sd0 ? 16'd1 : $unsigned(m);
  endfunction
endpackage

// File: rtl/cp_slot_counter.sv
// cp_slot_counter: TDM slot counter cycling 0..max_node-1 with non-positive ring size clamped to 1
module cp_slot_counter
  import control_plane_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] max_node,
  output logic [15:0]        slot
);
  logic [15:0] slot_q, slot_d;
  always_comb begin
    slot_d = slot_q + 16'd1 >= eff_nodes(max_node) ? 16'd0 : slot_q + 16'd1;
  end
  always_ff @(posedge clk) begin
    slot_q <= rst ? 16'd0 : slot_d;
  end
  assign slot = slot_q;
endmodule

// File: rtl/control_plane.sv
// control_plane: TDM transmit announcer and control-packet receive handshake for one ring node
module control_plane
  import control_plane_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic signed [15:0] node_id,
  input  logic signed [15:0] max_node,
  input  logic               data_rx_complete_flag,
  input  logic [31:0]        control_rx_packet,
  input  logic               tx_flag,
  input  logic [15:0]        top_of_stack,
  input  logic [15:0]        stack_pointer,
  input  logic               gpp_rtr,
  output logic [31:0]        control_tx_packet,
  output logic [15:0]        data_rx_node_id,
  output logic               data_tx_flag_out,
  output logic               data_rx_flag_out,
  output logic               gpp_trf
);
  tx_state_t   tx_state_q, tx_state_d;
  rx_state_t   rx_state_q, rx_state_d;
  logic [31:0] pkt_q, pkt_d;
  logic [15:0] rx_id_q, rx_id_d, slot, lim, src, dst;
  logic        tx_fl_q, tx_fl_d, rx_fl_q, rx_fl_d, trf_q, trf_d, node_ok, tx_go, accept;
  cp_slot_counter u_slot (
    .clk      (clk),
    .rst      (rst),
    .max_node (max_node),
    .slot     (slot)
  );
  always_comb begin
    lim        = eff_nodes(max_node);
    node_ok    = node_id >= 16'sd0 && $unsigned(node_id) < lim;
    tx_go      = node_ok && slot == $unsigned(node_id) && tx_flag && stack_pointer != 16'd0 &&
                 top_of_stack < lim && top_of_stack != $unsigned(node_id);
    tx_state_d = tx_state_q == TX_IDLE ? (tx_go ? TX_ANNOUNCE : TX_IDLE) :
                 tx_state_q == TX_ANNOUNCE ? TX_LAUNCH : TX_IDLE;
    pkt_d      = tx_state_q == TX_IDLE && tx_go ? {node_id, top_of_stack} : CP_IDLE_PKT;
    tx_fl_d    = tx_state_q == TX_ANNOUNCE;
  end
  always_comb begin
    src        = pkt_src(control_rx_packet);
    dst        = pkt_dst(control_rx_packet);
    accept     = rx_state_q == RX_IDLE && dst == $unsigned(node_id) && src != $unsigned(node_id) &&
                 src != 16'hFFFF && src < lim;
    rx_state_d = accept ? RX_BUSY :
                 rx_state_q == RX_BUSY && data_rx_complete_flag ? RX_DONE :
                 rx_state_q == RX_DONE && gpp_rtr ? RX_IDLE : rx_state_q;
    rx_id_d    = accept ? src : rx_id_q;
    rx_fl_d    = rx_state_d == RX_BUSY;
    trf_d      = rx_state_d == RX_DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state_q <= TX_IDLE;
      rx_state_q <= RX_IDLE;
      pkt_q      <= CP_IDLE_PKT;
      rx_id_q    <= 16'd0;
      tx_fl_q    <= 1'b0;
      rx_fl_q    <= 1'b0;
      trf_q      <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      rx_state_q <= rx_state_d;
      pkt_q      <= pkt_d;
      rx_id_q    <= rx_id_d;
      tx_fl_q    <= tx_fl_d;
      rx_fl_q    <= rx_fl_d;
      trf_q      <= trf_d;
    end
  end
  assign control_tx_packet = pkt_q;
  assign data_rx_node_id   = rx_id_q;
  assign data_tx_flag_out  = tx_fl_q;
  assign data_rx_flag_out  = rx_fl_q;
  assign gpp_trf           = trf_q;
endmodule

// File: tb/tb_control_plane.sv
// tb_control_plane: directed table and sequence checks of the control-plane controller
module tb_control_plane;
  import control_plane_pkg::*;
  typedef struct {
    logic [31:0] pkt;
    logic        cmp;
    logic        rtr;
    logic [15:0] e_id;
    logic        e_rxf;
    logic        e_trf;
  } vec_t;
  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic signed [15:0] node_id = 16'sd1;
  logic signed [15:0] max_node = 16'sd4;
  logic               data_rx_complete_flag = 1'b0;
  logic [31:0]        control_rx_packet = 32'hFFFF_FFFF;
  logic               tx_flag = 1'b0;
  logic [15:0]        top_of_stack = 16'd0;
  logic [15:0]        stack_pointer = 16'd0;
  logic               gpp_rtr = 1'b0;
  logic [31:0]        control_tx_packet;
  logic [15:0]        data_rx_node_id;
  logic               data_tx_flag_out, data_rx_flag_out, gpp_trf;
  int                 checks = 0;
  int                 errors = 0;
  vec_t               vt[16];
  control_plane dut (
    .clk                   (clk),
    .rst                   (rst),
    .node_id               (node_id),
    .max_node              (max_node),
    .data_rx_complete_flag (data_rx_complete_flag),
    .control_rx_packet     (control_rx_packet),
    .tx_flag               (tx_flag),
    .top_of_stack          (top_of_stack),
    .stack_pointer         (stack_pointer),
    .gpp_rtr               (gpp_rtr),
    .control_tx_packet     (control_tx_packet),
    .data_rx_node_id       (data_rx_node_id),
    .data_tx_flag_out      (data_tx_flag_out),
    .data_rx_flag_out      (data_rx_flag_out),
    .gpp_trf               (gpp_trf)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic chk_rx(input string tag, input logic [15:0] id, input logic rxf, input logic trf);
    chk({tag, " rx_id"}, {16'd0, data_rx_node_id}, {16'd0, id});
    chk({tag, " rx_flag"}, {31'd0, data_rx_flag_out}, {31'd0, rxf});
    chk({tag, " trf"}, {31'd0, gpp_trf}, {31'd0, trf});
  endtask
  task automatic chk_tx(input string tag, input logic [31:0] pkt, input logic txf);
    chk({tag, " tx_pkt"}, control_tx_packet, pkt);
    chk({tag, " tx_flag"}, {31'd0, data_tx_flag_out}, {31'd0, txf});
  endtask
  initial begin
    vt[0]  = '{32'h0001000F, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[1]  = '{32'h000AF0F0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[2]  = '{32'h00010001, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[3]  = '{32'h00040001, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[4]  = '{32'hFFFF0001, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0};
    vt[5]  = '{32'h00020001, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    vt[6]  = '{32'h00030001, 1'b0, 1'b0, 16'd2, 1'b1, 1'b0};
    vt[7]  = '{32'hFFFFFFFF, 1'b1, 1'b0, 16'd2, 1'b0, 1'b1};
    vt[8]  = '{32'hFFFFFFFF, 1'b0, 1'b0, 16'd2, 1'b0, 1'b1};
    vt[9]  = '{32'hFFFFFFFF, 1'b0, 1'b1, 16'd2, 1'b0, 1'b0};
    vt[10] = '{32'h00000001, 1'b0, 1'b0, 16'd0, 1'b1, 1'b0};
    vt[11] = '{32'hFFFFFFFF, 1'b1, 1'b0, 16'd0, 1'b0, 1'b1};
    vt[12] = '{32'h00030001, 1'b0, 1'b1, 16'd0, 1'b0, 1'b0};
    vt[13] = '{32'h00030001, 1'b0, 1'b1, 16'd3, 1'b1, 1'b0};
    vt[14] = '{32'hFFFFFFFF, 1'b1, 1'b1, 16'd3, 1'b0, 1'b1};
    vt[15] = '{32'hFFFFFFFF, 1'b0, 1'b1, 16'd3, 1'b0, 1'b0};
    @(negedge clk);
    @(negedge clk);
    chk_tx("reset", 32'hFFFF_FFFF, 1'b0);
    chk_rx("reset", 16'd0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      control_rx_packet     = vt[i].pkt;
      data_rx_complete_flag = vt[i].cmp;
      gpp_rtr               = vt[i].rtr;
      @(negedge clk);
      chk_rx($sformatf("vec%0d", i), vt[i].e_id, vt[i].e_rxf, vt[i].e_trf);
      chk_tx($sformatf("vec%0d", i), 32'hFFFF_FFFF, 1'b0);
    end
    control_rx_packet     = 32'hFFFF_FFFF;
    data_rx_complete_flag = 1'b0;
    gpp_rtr               = 1'b0;
    rst           = 1'b1;
    tx_flag       = 1'b1;
    stack_pointer = 16'd2;
    top_of_stack  = 16'd3;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk_tx($sformatf("tx edge%0d", k), (k == 1 || k == 5) ? 32'h0001_0003 : 32'hFFFF_FFFF, k == 2);
    end
    tx_flag = 1'b0;
    repeat (3) @(negedge clk);
    tx_flag      = 1'b1;
    top_of_stack = 16'h00A5;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_tx($sformatf("bad dst a5 %0d", k), 32'hFFFF_FFFF, 1'b0);
    end
    top_of_stack = 16'd1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk_tx($sformatf("bad dst self %0d", k), 32'hFFFF_FFFF, 1'b0);
    end
    tx_flag           = 1'b0;
    control_rx_packet = 32'h0002_0001;
    @(negedge clk);
    chk_rx("midrst busy", 16'd2, 1'b1, 1'b0);
    rst               = 1'b1;
    control_rx_packet = 32'hFFFF_FFFF;
    @(negedge clk);
    chk_rx("midrst reset", 16'd0, 1'b0, 1'b0);
    rst               = 1'b0;
    control_rx_packet = 32'h0003_0001;
    @(negedge clk);
    chk_rx("midrst fresh", 16'd3, 1'b1, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/control_plane.md
# control_plane

Per-node control-plane controller for the photonic interconnect. It runs a TDM slot schedule to decide when this node may announce a data transfer on the control channel. It also decodes incoming control packets addressed to this node, enables the data-plane receiver, and hands completed receptions to the local general-purpose processor (GPP) through a trf/rtr handshake.

## Interface
Parameters: none. Node identity and ring size are run-time inputs.
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- node_id  in  16 (signed)  this node's id; valid range 0..max_node-1.
- max_node  in  16 (signed)  number of nodes on the ring; a value ≤0 is treated as 1.
- data_rx_complete_flag  in  1  data plane finished receiving the current transfer.
- control_rx_packet  in  32  incoming control word, {src[31:16], dst[15:0]}.
- tx_flag  in  1  GPP requests a transmit.
- top_of_stack  in  16  destination node id of the pending transmit.
- stack_pointer  in  16  GPP outgoing-stack depth; 0 means empty.
- gpp_rtr  in  1  GPP ready-to-receive / acknowledge.
- control_tx_packet  out  32  outgoing control word, {node_id, dst}; idle value 32'hFFFF_FFFF.
- data_rx_node_id  out  16  source id of the accepted transfer.
- data_tx_flag_out  out  1  launch the data-plane transmitter.
- data_rx_flag_out  out  1  enable the data-plane receiver.
- gpp_trf  out  1  a received transfer is ready for the GPP.

## Operation
- All outputs are registered.
- Reset values: control_tx_packet=FFFF_FFFF, data_rx_node_id=0, data_tx_flag_out=0, data_rx_flag_out=0, gpp_trf=0, slot=0, both FSMs idle.
- Slot counter: counts 0..max_node-1 once per cycle and wraps to 0. If max_node changes below the current slot, the counter wraps to 0 on the next cycle.
- Tx FSM, states TX_IDLE → TX_ANNOUNCE → TX_LAUNCH → TX_IDLE:
  - Leave TX_IDLE when slot==node_id, tx_flag=1, stack_pointer≠0, top_of_stack<max_node (unsigned compare) and top_of_stack≠node_id.
  - TX_ANNOUNCE: control_tx_packet={node_id, top_of_stack} for 1 cycle.
  - TX_LAUNCH: data_tx_flag_out=1 for 1 cycle; control_tx_packet returns to idle.
  - An invalid destination or an out-of-range node_id never transmits.
- Rx FSM, states RX_IDLE → RX_BUSY → RX_DONE → RX_IDLE:
  - Accept a packet only in RX_IDLE, and only when dst==node_id, src≠node_id (own echo), src≠16'hFFFF (idle) and src<max_node.
  - On accept: data_rx_node_id=src, data_rx_flag_out=1.
  - RX_BUSY plus data_rx_complete_flag=1 → RX_DONE: data_rx_flag_out=0, gpp_trf=1.
  - RX_DONE plus gpp_rtr=1 → RX_IDLE: gpp_trf=0. data_rx_node_id is held until the next accept.
  - Packets arriving outside RX_IDLE are dropped; there is no queue.
  - data_rx_complete_flag outside RX_BUSY is ignored.
- Tx and Rx run independently, so simultaneous transmit and receive is allowed.

## Timing
- An input sampled at edge N produces its output change after edge N (1-cycle latency).
- Transmit: slot match at edge N → packet valid in cycle N+1 → data_tx_flag_out in cycle N+2.
- Worst-case wait for a slot is max_node cycles.
- rx accept and complete on consecutive edges are legal: the minimum busy time is 1 cycle.
- gpp_rtr already high when RX_DONE is entered: gpp_trf is high for exactly 1 cycle.
- rst mid-operation: every output returns to its reset value at the next edge; in-flight transfers are abandoned.

## Structure
- control_plane_pkg holds:
  - CP_IDLE_PKT = 32'hFFFF_FFFF;
  - the src/dst field-slice functions;
  - typedef enums tx_state_t and rx_state_t.
- One sub-module, cp_slot_counter: inputs clk, rst, max_node; output slot. It contains the wrap and ≤0 clamp logic.

## Test plan
- Ignore own echo: node_id=1, max_node=4, control_rx_packet=0x0001000F after reset, tx_flag=0 → all outputs stay at reset values, control_tx_packet=FFFF_FFFF.
- Reject foreign destination: control_rx_packet=0x000AF0F0 with a data_rx_complete_flag pulse → no change on any output.
- Receive handshake: packet 0x00020001 → data_rx_flag_out=1, data_rx_node_id=2; complete pulse → data_rx_flag_out=0, gpp_trf=1; gpp_rtr=1 → gpp_trf=0 next edge.
- Transmit: tx_flag=1, stack_pointer=2, top_of_stack=3 → at slot 1, control_tx_packet=0x00010003 for 1 cycle, then data_tx_flag_out=1 for 1 cycle.
- Invalid destination: top_of_stack=0xA5 or 1, with tx_flag=1 → no transmit across ≥8 cycles.
- Reset mid-receive: assert rst while RX_BUSY → data_rx_flag_out=0, data_rx_node_id=0 next edge; a fresh packet 0x00030001 is then accepted.
